// File: rtl/sram_word_bridge.sv
// Bridge from the picorv32 native memory bus to a single 8-bit OpenRAM macro.
// Each 32-bit access is split into four byte-lane SRAM cycles; mem_ready pulses six cycles after accept.
module sram_word_bridge #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              sram_csb0,
    output logic              sram_web0,
    output logic [ADDR_W-1:0] sram_addr0,
    output logic [7:0]        sram_din0,
    input  logic [7:0]        sram_dout0
);

    typedef enum logic [2:0] {IDLE, CMD, LAST, RESP, MISS} state_e;

    typedef struct packed {
        logic       csb;
        logic       web;
        logic [7:0] din;
    } lane_cmd_t;

    // Read: every lane selected. Write: only strobed lanes selected, others left idle.
    function automatic lane_cmd_t lane_cmd(input logic [31:0] wdata,
                                           input logic [3:0]  wstrb,
                                           input logic [1:0]  lane);
        lane_cmd_t c;
        c.csb = 1'b1;
        c.web = 1'b1;
        c.din = wdata[{lane, 3'b000} +: 8];
        if (wstrb == 4'b0000) begin
            c.csb = 1'b0;
        end else if (wstrb[lane]) begin
            c.csb = 1'b0;
            c.web = 1'b0;
        end
        return c;
    endfunction

    state_e            state_q,  state_d;
    logic [1:0]        lane_q,   lane_d;
    logic [ADDR_W-3:0] word_q,   word_d;
    logic [31:0]       wdata_q,  wdata_d;
    logic [3:0]        wstrb_q,  wstrb_d;
    logic [23:0]       rbuf_q,   rbuf_d;
    logic              csb0_q,   csb0_d;
    logic              web0_q,   web0_d;
    logic [ADDR_W-1:0] addr0_q,  addr0_d;
    logic [7:0]        din0_q,   din0_d;
    logic              ready_q,  ready_d;
    logic [31:0]       rdata_q,  rdata_d;

    lane_cmd_t  cmd;
    logic [1:0] lane_nxt;
    logic       hit;
    logic       unused_inputs;

    assign unused_inputs = ^{mem_instr, mem_addr[1:0]};
    assign hit           = (mem_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
    assign lane_nxt      = lane_q + 2'd1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rbuf_d  = rbuf_q;
        csb0_d  = 1'b1;
        web0_d  = 1'b1;
        addr0_d = addr0_q;
        din0_d  = din0_q;
        ready_d = 1'b0;
        rdata_d = rdata_q;
        cmd     = '{csb: 1'b1, web: 1'b1, din: 8'h00};

        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    word_d  = mem_addr[ADDR_W-1:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    if (hit) begin
                        state_d = CMD;
                        lane_d  = 2'd0;
                        cmd     = lane_cmd(mem_wdata, mem_wstrb, 2'd0);
                        csb0_d  = cmd.csb;
                        web0_d  = cmd.web;
                        addr0_d = {mem_addr[ADDR_W-1:2], 2'd0};
                        if (!cmd.web) din0_d = cmd.din;
                    end else begin
                        state_d = MISS;
                        ready_d = 1'b1;
                        rdata_d = 32'h0;
                    end
                end
            end
            CMD: begin
                // Data for the previous lane's read command is on sram_dout0 now.
                if (wstrb_q == 4'b0000) begin
                    case (lane_q)
                        2'd1:    rbuf_d[7:0]   = sram_dout0;
                        2'd2:    rbuf_d[15:8]  = sram_dout0;
                        2'd3:    rbuf_d[23:16] = sram_dout0;
                        default: ;
                    endcase
                end
                lane_d = lane_nxt;
                if (lane_q == 2'd3) begin
                    state_d = LAST;
                end else begin
                    cmd     = lane_cmd(wdata_q, wstrb_q, lane_nxt);
                    csb0_d  = cmd.csb;
                    web0_d  = cmd.web;
                    addr0_d = {word_q, lane_nxt};
                    if (!cmd.web) din0_d = cmd.din;
                end
            end
            LAST: begin
                state_d = RESP;
                ready_d = 1'b1;
                if (wstrb_q == 4'b0000) rdata_d = {sram_dout0, rbuf_q};
            end
            RESP:    state_d = IDLE;
            MISS:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            word_q  <= '0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rbuf_q  <= 24'h0;
            csb0_q  <= 1'b1;
            web0_q  <= 1'b1;
            addr0_q <= '0;
            din0_q  <= 8'h00;
            ready_q <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rbuf_q  <= rbuf_d;
            csb0_q  <= csb0_d;
            web0_q  <= web0_d;
            addr0_q <= addr0_d;
            din0_q  <= din0_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_csb0  = csb0_q;
    assign sram_web0  = web0_q;
    assign sram_addr0 = addr0_q;
    assign sram_din0  = din0_q;
    assign mem_ready  = ready_q;
    assign mem_rdata  = rdata_q;

endmodule

// File: doc/sram_word_bridge.md
Name: sram_word_bridge

Overview:
- Adapter between the picorv32 native memory bus and one 8-bit-wide OpenRAM macro (sram_8_1024_sky130A: csb0/web0 active-low, addr0, din0, dout0).
- Serialises each 32-bit core access into four byte-lane SRAM cycles.
- Honours per-byte write strobes and reassembles read words.
- Returns mem_ready once per accepted request, at a fixed latency.

Parameters:
- ADDR_W, 10, SRAM byte-address width; macro depth is 2^ADDR_W bytes.
- BASE_ADDR, 32'h0000_0000, window base. Only bits [31:ADDR_W] are compared; low bits are ignored.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- mem_valid  in  1  core request valid; held until mem_ready.
- mem_instr  in  1  instruction fetch flag; ignored.
- mem_addr  in  32  byte address; bits [1:0] ignored (word aligned).
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write enables; 4'b0000 means read.
- mem_rdata  out  32  read word; valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.
- sram_csb0  out  1  macro chip select, active-low.
- sram_web0  out  1  macro write enable, active-low.
- sram_addr0  out  ADDR_W  macro byte address.
- sram_din0  out  8  macro write data.
- sram_dout0  in  8  macro read data; valid the cycle after a read command.

Behaviour:
- Reset (asynchronous, immediate):
  - sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0.
  - mem_ready=0, mem_rdata=0, state=IDLE, lane counter=0.
  - Reset mid-transaction aborts it; no mem_ready is issued afterwards.
- All outputs are registered.
- FSM states: IDLE, CMD, LAST, RESP, MISS.
- IDLE:
  - SRAM deselected (csb0=1, web0=1).
  - On the edge with mem_valid=1: latch addr/wdata/wstrb.
  - If mem_addr[31:ADDR_W]==BASE_ADDR[31:ADDR_W], go to CMD with lane=0; otherwise go to MISS.
- CMD, lane k = 0..3, one cycle each:
  - sram_addr0 = {latched_addr[ADDR_W-1:2], k[1:0]}.
  - Read (wstrb==0): csb0=0, web0=1.
  - Write with wstrb[k]=1: csb0=0, web0=0, din0 = wdata[8k+7:8k].
  - Write with wstrb[k]=0: csb0=1, web0=1, i.e. lane idle and memory byte untouched.
  - Read capture: in the cycle after lane k's command, sram_dout0 is latched into rdata byte k. Byte 0 is captured at the end of the lane-1 cycle, and so on.
  - After lane 3, go to LAST.
- LAST:
  - SRAM deselected.
  - Read: capture byte 3 from sram_dout0.
  - Go to RESP.
- RESP:
  - mem_ready=1 for exactly one cycle.
  - Read: mem_rdata = assembled word. Write: mem_rdata holds its previous value.
  - Next state IDLE. mem_valid is not sampled in RESP, so no double accept while the core still holds valid.
- MISS:
  - No SRAM command.
  - mem_ready=1 for one cycle with mem_rdata=32'h0; writes are discarded.
  - Next state IDLE.
- Latency, counting the accept edge as edge 0:
  - In-window: mem_ready high in cycle 6, identical for reads and writes.
  - Miss: mem_ready high in cycle 1.
  - Back-to-back in-window requests: one every 7 cycles.
- Illegal input changes: if mem_valid drops or inputs change mid-transaction, the bridge still completes using the latched values and still pulses mem_ready.
- Address wrap: byte addresses do not increment across the word; lanes are always {word, 0..3}. The last word (0x3FC..0x3FF for ADDR_W=10) has no wrap issue.

Test Plan:
- Reset: assert rstn=0 mid-CMD -> csb0=1, web0=1, mem_ready=0, mem_rdata=0 immediately; with rstn=1 and no request, state stays IDLE.
- Full write then read:
  - Write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF -> SRAM writes bytes 0x10..0x13 = EF,BE,AD,DE and mem_ready pulses in cycle 6.
  - Read 0x10 -> mem_rdata 0xDEADBEEF with a single-cycle mem_ready.
- Partial write: after the full write, write 0x10 with wdata 0x11223344, wstrb 4'b0101 -> lanes 1 and 3 show csb0=1; read back 0xDE22BE44.
- Back-to-back: hold mem_valid high across two reads (0x00 then 0x3FC) -> exactly two mem_ready pulses, 7 cycles apart, with correct data. Include the top-word read at 0x3FC.
- Out of window: read 0x0000_0400 with BASE_ADDR=0 -> mem_ready in cycle 1, mem_rdata=0, csb0 stays 1. Write to 0x400 -> SRAM contents unchanged.
- Misaligned address: read 0x13 -> identical to a read of 0x10.
